interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter WIDTH, default 32, width of vector address output.
REQ-002 Parameter VEC0, default 32'h0000_0100, handler address for source 0.
REQ-003 Parameter VEC1, default 32'h0000_0200, handler address for source 1.
REQ-004 Parameter VEC2, default 32'h0000_0300, handler address for source 2.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port clk  input  1  single rising-edge clock.
REQ-007 Port IRQ  input  3  raw interrupt request lines; bit 2 highest priority, bit 0 lowest.
REQ-008 Port int_ack  input  1  one-cycle pulse from the pipeline: the offered interrupt is taken this cycle.
REQ-009 Port eret  input  1  one-cycle pulse from the pipeline: the current handler returns.
REQ-010 Port ei  input  1  one-cycle pulse: set global enable.
REQ-011 Port di  input  1  one-cycle pulse: clear global enable.
REQ-012 Port int_req  output  1  an interrupt is offered to the pipeline.
REQ-013 Port int_id  output  2  source index of the offered interrupt, 0..2.
REQ-014 Port int_vec  output  WIDTH  handler address of the offered interrupt.
REQ-015 Port IRW  output  3  pending (waiting) bits, one per source.
REQ-016 Port ISR  output  3  in-service bits, one per source.

Function
REQ-017 Internal registers SHALL be irq_prev[2:0], pending[2:0], in_service[2:0], and ie.
REQ-018 A request SHALL be detected on a rising edge only: pending[i] is set when IRQ[i]=1 and irq_prev[i]=0; irq_prev SHALL track IRQ every cycle.
REQ-019 IRQ held high SHALL produce one request; a new request needs IRQ to go low and then high again.
REQ-020 Current level SHALL be the index of the highest set bit of in_service, or -1 when in_service=0.
REQ-021 Candidate SHALL be the highest-index pending bit strictly above the current level.
REQ-022 int_req SHALL be high when ie=1 and a candidate exists; this is combinational from registers.
REQ-023 When int_req is high, int_id and int_vec SHALL reflect the candidate; otherwise both SHALL be 0.
REQ-024 Latency: an IRQ rising edge sampled at clock edge N SHALL make int_req high in the cycle after edge N.
REQ-025 On int_ack with int_req high: clear pending[int_id], set in_service[int_id], and clear ie.
REQ-026 int_ack with int_req low SHALL be ignored.
REQ-027 On eret: clear the highest set bit of in_service and set ie; eret with in_service=0 only sets ie.
REQ-028 Nesting: a higher-priority pending source SHALL be offered while a lower one is in service, once ie=1.
REQ-029 An equal- or lower-priority source SHALL wait in pending until in_service drops below its level.
REQ-030 A new edge on source i in the same cycle as an ack of source i SHALL leave pending[i]=1; the set wins.
REQ-031 eret and int_ack in the same cycle: eret SHALL clear the highest bit of the old in_service, int_ack SHALL set its bit, and ie SHALL end at 0.
REQ-032 ei and di in the same cycle: di SHALL win; int_ack/eret updates of ie SHALL take precedence over ei/di.
REQ-033 IRW SHALL equal pending, and ISR SHALL equal in_service.

Reset
REQ-034 On rst=1, asynchronously: irq_prev=0, pending=0, in_service=0, ie=1; int_req=0, int_id=0, int_vec=0, IRW=0, ISR=0.
REQ-035 A reset mid-handler SHALL discard all pending and in-service state; IRQ lines already high at release SHALL not create requests until they go low and then high again.

Verification
REQ-036 Pulse IRQ[0] for one cycle -> next cycle int_req=1, int_id=0, int_vec=32'h100, IRW=3'b001; int_ack -> IRW=0, ISR=3'b001, int_req=0.
REQ-037 During the source-0 handler, eret at t1, then IRQ[1] pulse -> int_vec=32'h200; int_ack -> ISR=3'b010.
REQ-038 Source 1 in service with ie re-enabled via ei, then IRQ[2] pulse -> int_req=1, int_id=2, int_vec=32'h300; ack -> ISR=3'b110; eret -> ISR=3'b010.
REQ-039 Source 2 in service, IRQ[0] pulse -> IRW=3'b001 and int_req=0 until eret empties ISR, then int_id=0.
REQ-040 IRQ[0] held high 10 cycles -> exactly one request; IRQ[1] and IRQ[2] pulsed together -> int_id=2 first, then int_id=1 after ack/eret.
REQ-041 Assert rst with ISR=3'b011 and IRW=3'b100 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/interrupt_controller.sv
// Three-source prioritised interrupt controller with edge-detected requests,
// nested in-service tracking and a global enable.
module interrupt_controller #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] VEC0  = 'h0000_0100,
    parameter logic [WIDTH-1:0] VEC1  = 'h0000_0200,
    parameter logic [WIDTH-1:0] VEC2  = 'h0000_0300
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [2:0]       IRQ,
    input  logic             int_ack,
    input  logic             eret,
    input  logic             ei,
    input  logic             di,
    output logic             int_req,
    output logic [1:0]       int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [2:0]       IRW,
    output logic [2:0]       ISR
);

    logic [2:0]       r_irq_prev;
    logic [2:0]       r_pending;
    logic [2:0]       r_in_service;
    logic             r_ie;
    logic             r_armed;

    logic [2:0]       w_rise;
    logic [2:0]       w_mask;
    logic [2:0]       w_cand;
    logic             w_req;
    logic [1:0]       w_id;
    logic [WIDTH-1:0] w_vec;
    logic             w_take;
    logic [2:0]       w_ack_bit;
    logic [2:0]       w_top_isr;
    logic [2:0]       w_ret_bit;

    assign w_rise = IRQ & ~r_irq_prev;

    // Only pending sources strictly above the current in-service level qualify.
    always_comb begin
        w_mask    = 3'b111;
        w_top_isr = '0;
        if (r_in_service[2]) begin
            w_mask    = 3'b000;
            w_top_isr = 3'b100;
        end else if (r_in_service[1]) begin
            w_mask    = 3'b100;
            w_top_isr = 3'b010;
        end else if (r_in_service[0]) begin
            w_mask    = 3'b110;
            w_top_isr = 3'b001;
        end
    end

    assign w_cand = r_pending & w_mask;
    assign w_req  = r_ie & (|w_cand);

    always_comb begin
        w_id  = '0;
        w_vec = '0;
        if (w_req) begin
            if (w_cand[2]) begin
                w_id  = 2'd2;
                w_vec = VEC2;
            end else if (w_cand[1]) begin
                w_id  = 2'd1;
                w_vec = VEC1;
            end else begin
                w_id  = 2'd0;
                w_vec = VEC0;
            end
        end
    end

    assign w_take    = int_ack & w_req;
    assign w_ack_bit = w_take ? (3'b001 << w_id) : '0;
    assign w_ret_bit = eret ? w_top_isr : '0;

    // r_armed suppresses edge detection on the first clock after reset release,
    // so lines already high when reset drops do not raise requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_ie         <= 1'b1;
            r_armed      <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_irq_prev   <= IRQ;
            r_pending    <= (r_pending & ~w_ack_bit) | (r_armed ? w_rise : 3'b000);
            r_in_service <= (r_in_service & ~w_ret_bit) | w_ack_bit;
            if (w_take)
                r_ie <= 1'b0;
            else if (eret)
                r_ie <= 1'b1;
            else if (di)
                r_ie <= 1'b0;
            else if (ei)
                r_ie <= 1'b1;
        end
    end

    assign int_req = w_req;
    assign int_id  = w_id;
    assign int_vec = w_vec;
    assign IRW     = r_pending;
    assign ISR     = r_in_service;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge
// monitor pops one per cycle and compares against the DUT outputs.
module tb_interrupt_controller;

    logic        rst;
    logic        clk;
    logic [2:0]  IRQ;
    logic        int_ack;
    logic        eret;
    logic        ei;
    logic        di;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  IRW;
    logic [2:0]  ISR;

    typedef struct {
        string       name;
        logic        req;
        logic [1:0]  id;
        logic [31:0] vec;
        logic [2:0]  irw;
        logic [2:0]  isr;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_err;

    interrupt_controller #(
        .WIDTH (32),
        .VEC0  (32'h0000_0100),
        .VEC1  (32'h0000_0200),
        .VEC2  (32'h0000_0300)
    ) dut (
        .rst     (rst),
        .clk     (clk),
        .IRQ     (IRQ),
        .int_ack (int_ack),
        .eret    (eret),
        .ei      (ei),
        .di      (di),
        .int_req (int_req),
        .int_id  (int_id),
        .int_vec (int_vec),
        .IRW     (IRW),
        .ISR     (ISR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (int_req !== e.req || int_id !== e.id || int_vec !== e.vec ||
                IRW !== e.irw || ISR !== e.isr) begin
                n_err++;
                $display("FAIL %s: got req=%b id=%0d vec=%h IRW=%b ISR=%b, want req=%b id=%0d vec=%h IRW=%b ISR=%b",
                         e.name, int_req, int_id, int_vec, IRW, ISR,
                         e.req, e.id, e.vec, e.irw, e.isr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        int_ack = 1'b0;
        eret    = 1'b0;
        ei      = 1'b0;
        di      = 1'b0;
    endtask

    task automatic chk(input string name, input logic req, input logic [1:0] id,
                       input logic [31:0] vec, input logic [2:0] irw, input logic [2:0] isr);
        exp_t e;
        e.name = name;
        e.req  = req;
        e.id   = id;
        e.vec  = vec;
        e.irw  = irw;
        e.isr  = isr;
        q.push_back(e);
    endtask

    task automatic pulse_irq(input logic [2:0] v);
        IRQ = v;
        tick();
        IRQ = 3'b000;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        IRQ     = '0;
        int_ack = 1'b0;
        eret    = 1'b0;
        ei      = 1'b0;
        di      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", 0, 0, 32'h0, 3'b000, 3'b000);
        tick();

        // Single source-0 request, then acknowledge.
        pulse_irq(3'b001);
        chk("irq0_offer", 1, 0, 32'h100, 3'b001, 3'b000);
        int_ack = 1'b1; tick();
        chk("irq0_ack", 0, 0, 32'h0, 3'b000, 3'b001);

        eret = 1'b1; tick();
        chk("eret0", 0, 0, 32'h0, 3'b000, 3'b000);
        pulse_irq(3'b010);
        chk("irq1_offer", 1, 1, 32'h200, 3'b010, 3'b000);
        int_ack = 1'b1; tick();
        chk("irq1_ack", 0, 0, 32'h0, 3'b000, 3'b010);

        // Nesting source 2 over source 1.
        ei = 1'b1; tick();
        chk("ei_in_irq1", 0, 0, 32'h0, 3'b000, 3'b010);
        pulse_irq(3'b100);
        chk("irq2_nest", 1, 2, 32'h300, 3'b100, 3'b010);
        int_ack = 1'b1; tick();
        chk("irq2_ack", 0, 0, 32'h0, 3'b000, 3'b110);
        eret = 1'b1; tick();
        chk("eret2", 0, 0, 32'h0, 3'b000, 3'b010);

        // Lower priority waits until in_service empties.
        pulse_irq(3'b100);
        chk("irq2_again", 1, 2, 32'h300, 3'b100, 3'b010);
        int_ack = 1'b1; tick();
        chk("irq2_ack2", 0, 0, 32'h0, 3'b000, 3'b110);
        pulse_irq(3'b001);
        chk("irq0_blocked", 0, 0, 32'h0, 3'b001, 3'b110);
        eret = 1'b1; tick();
        chk("irq0_still", 0, 0, 32'h0, 3'b001, 3'b010);
        eret = 1'b1; tick();
        chk("irq0_released", 1, 0, 32'h100, 3'b001, 3'b000);
        int_ack = 1'b1; tick();
        chk("irq0_ack2", 0, 0, 32'h0, 3'b000, 3'b001);
        eret = 1'b1; tick();
        chk("idle1", 0, 0, 32'h0, 3'b000, 3'b000);

        // Held level gives exactly one request.
        IRQ = 3'b001; tick();
        chk("held_offer", 1, 0, 32'h100, 3'b001, 3'b000);
        int_ack = 1'b1; tick();
        chk("held_ack", 0, 0, 32'h0, 3'b000, 3'b001);
        eret = 1'b1; tick();
        chk("held_eret", 0, 0, 32'h0, 3'b000, 3'b000);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("held_quiet", 0, 0, 32'h0, 3'b000, 3'b000);
        end
        IRQ = 3'b000; tick();
        chk("held_low", 0, 0, 32'h0, 3'b000, 3'b000);

        // Simultaneous sources 1 and 2.
        pulse_irq(3'b110);
        chk("pair_2first", 1, 2, 32'h300, 3'b110, 3'b000);
        int_ack = 1'b1; tick();
        chk("pair_ack2", 0, 0, 32'h0, 3'b010, 3'b100);
        eret = 1'b1; tick();
        chk("pair_1next", 1, 1, 32'h200, 3'b010, 3'b000);
        int_ack = 1'b1; tick();
        chk("pair_ack1", 0, 0, 32'h0, 3'b000, 3'b010);
        eret = 1'b1; tick();
        chk("idle2", 0, 0, 32'h0, 3'b000, 3'b000);

        // Ack without a request is ignored and leaves ie set.
        int_ack = 1'b1; tick();
        chk("stray_ack", 0, 0, 32'h0, 3'b000, 3'b000);
        pulse_irq(3'b001);
        chk("after_stray", 1, 0, 32'h100, 3'b001, 3'b000);
        ei = 1'b1; di = 1'b1; tick();
        chk("di_wins", 0, 0, 32'h0, 3'b001, 3'b000);
        ei = 1'b1; tick();
        chk("ei_reoffer", 1, 0, 32'h100, 3'b001, 3'b000);

        // New edge coincident with ack of the same source stays pending.
        IRQ = 3'b001; int_ack = 1'b1; tick();
        IRQ = 3'b000;
        chk("set_wins", 0, 0, 32'h0, 3'b001, 3'b001);
        ei = 1'b1; tick();
        chk("level_block", 0, 0, 32'h0, 3'b001, 3'b001);
        pulse_irq(3'b100);
        chk("irq2_over0", 1, 2, 32'h300, 3'b101, 3'b001);
        eret = 1'b1; int_ack = 1'b1; tick();
        chk("eret_ack", 0, 0, 32'h0, 3'b001, 3'b100);
        eret = 1'b1; tick();
        chk("after_eret_ack", 1, 0, 32'h100, 3'b001, 3'b000);
        int_ack = 1'b1; tick();
        chk("build_isr0", 0, 0, 32'h0, 3'b000, 3'b001);
        ei = 1'b1; tick();
        pulse_irq(3'b010);
        chk("build_offer1", 1, 1, 32'h200, 3'b010, 3'b001);
        int_ack = 1'b1; tick();
        pulse_irq(3'b100);
        chk("pre_reset", 0, 0, 32'h0, 3'b100, 3'b011);

        // Asynchronous reset: outputs clear before the next rising edge.
        tick();
        rst = 1'b1;
        chk("async_reset", 0, 0, 32'h0, 3'b000, 3'b000);
        IRQ = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("held_at_release", 0, 0, 32'h0, 3'b000, 3'b000);
        tick();
        IRQ = 3'b000; tick();
        pulse_irq(3'b001);
        chk("post_reset_irq", 1, 0, 32'h100, 3'b001, 3'b000);

        tick();
        tick();
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
